// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS instruction/data memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } arb_owner_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wr_en;
    logic        rd;
  } mem_cmd_t;

endpackage

// File: rtl/mips_mem_watchdog.sv
// Counts enabled cycles; expires once TIMEOUT_CYCLES cycles have elapsed (0 = never).
module mips_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                count <= '0;
    else if (clear)            count <= '0;
    else if (en && !expired)   count <= count + CW'(1);
  end

  assign expired = (TIMEOUT_CYCLES != 0) && en && (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port word memory between the fetch and data ports of a MIPS32 core,
// with a fetch starvation guard and a response watchdog.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int          MAX_DATA_STREAK = 4,
  parameter int          TIMEOUT_CYCLES  = 64,
  parameter logic [31:0] TIMEOUT_DATA    = 32'hDEAD_DEAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        InstMem_Read,
  input  logic [29:0] InstMem_Address,
  output logic [31:0] InstMem_In,
  output logic        InstMem_Ready,
  input  logic        DataMem_Read,
  input  logic [3:0]  DataMem_Write,
  input  logic [29:0] DataMem_Address,
  input  logic [31:0] DataMem_Out,
  output logic [31:0] DataMem_In,
  output logic        DataMem_Ready,
  output logic        Mem_Read,
  output logic [3:0]  Mem_Write,
  output logic [29:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  input  logic [31:0] Mem_ReadData,
  input  logic        Mem_Ready,
  output logic        Mem_Error
);

  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  arb_state_t    state, state_nxt;
  arb_owner_t    owner;
  mem_cmd_t      cmd;
  logic [SW-1:0] streak;
  logic          data_wr, data_req, grant_data, grant_inst;
  logic          expired, done, timeout;
  logic [31:0]   rsp;

  // A set read enable overrides any byte-write enables on the data port.
  assign data_wr    = (|DataMem_Write) && !DataMem_Read;
  assign data_req   = DataMem_Read || data_wr;
  assign grant_data = data_req && (!InstMem_Read || (streak != SW'(MAX_DATA_STREAK)));
  assign grant_inst = InstMem_Read && !grant_data;

  mips_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != WAIT),
    .en      (state == WAIT),
    .expired (expired)
  );

  // A real response in the expiry cycle takes precedence over the timeout.
  assign done    = (state == WAIT) && (Mem_Ready || expired);
  assign timeout = (state == WAIT) && expired && !Mem_Ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_inst) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd       <= '0;
      owner     <= OWN_INST;
      streak    <= '0;
      Mem_Error <= 1'b0;
    end else begin
      if (timeout) Mem_Error <= 1'b1;
      if (state == IDLE) begin
        if (grant_data) begin
          owner     <= OWN_DATA;
          cmd.addr  <= DataMem_Address;
          cmd.rd    <= DataMem_Read;
          cmd.wr_en <= DataMem_Read ? 4'h0 : DataMem_Write;
          cmd.wdata <= data_wr ? DataMem_Out : 32'h0;
        end else if (grant_inst) begin
          owner     <= OWN_INST;
          cmd.addr  <= InstMem_Address;
          cmd.rd    <= 1'b1;
          cmd.wr_en <= 4'h0;
          cmd.wdata <= 32'h0;
        end
        if (!InstMem_Read || grant_inst)
          streak <= '0;
        else if (grant_data && (streak != SW'(MAX_DATA_STREAK)))
          streak <= streak + SW'(1);
      end
    end
  end

  assign Mem_Address   = cmd.addr;
  assign Mem_WriteData = cmd.wdata;

  always_comb begin
    Mem_Read      = 1'b0;
    Mem_Write     = 4'h0;
    InstMem_Ready = 1'b0;
    DataMem_Ready = 1'b0;
    InstMem_In    = 32'h0;
    DataMem_In    = 32'h0;
    rsp           = 32'h0;
    if (state == ISSUE) begin
      Mem_Read  = cmd.rd;
      Mem_Write = cmd.wr_en;
    end
    if (done) begin
      if (cmd.rd) rsp = timeout ? TIMEOUT_DATA : Mem_ReadData;
      if (owner == OWN_DATA) begin
        DataMem_Ready = 1'b1;
        DataMem_In    = rsp;
      end else begin
        InstMem_Ready = 1'b1;
        InstMem_In    = rsp;
      end
    end
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares one single-port word memory between the MIPS32 core's instruction-fetch and data-access interfaces. It sits between the CPU memory ports and the unified memory model or controller. Each CPU request becomes a one-cycle memory command, and the completion is routed back to the requester that issued it. A starvation guard and a response watchdog keep the CPU from hanging.

## Interface
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending; then the fetch is forced.
- TIMEOUT_CYCLES, 64: WAIT cycles before the watchdog fires; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_DEAD: read data returned on a timed-out access.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstMem_Read  in  1  fetch request, held until InstMem_Ready.
- InstMem_Address  in  30  fetch word address.
- InstMem_In  out  32  fetch data; valid only while InstMem_Ready=1, else 0.
- InstMem_Ready  out  1  one-cycle fetch completion.
- DataMem_Read  in  1  data read request.
- DataMem_Write  in  4  byte-write enables; a write is `|DataMem_Write && !DataMem_Read`.
- DataMem_Address  in  30  data word address.
- DataMem_Out  in  32  write data.
- DataMem_In  out  32  read data; valid only while DataMem_Ready=1, else 0.
- DataMem_Ready  out  1  one-cycle data completion (read or write).
- Mem_Read  out  1  one-cycle read strobe.
- Mem_Write  out  4  one-cycle byte-write strobe.
- Mem_Address  out  30  command address, registered.
- Mem_WriteData  out  32  command write data, registered.
- Mem_ReadData  in  32  memory read data, valid with Mem_Ready.
- Mem_Ready  in  1  exactly one pulse per command, at least 1 cycle after the strobe.
- Mem_Error  out  1  sticky; set by any watchdog timeout.

## Operation
- FSM states:
  - IDLE: arbitrates and latches the winning request.
  - ISSUE: drives the strobe for exactly one cycle.
  - WAIT: waits for Mem_Ready or the watchdog.
- Transitions:
  - IDLE to ISSUE when any request is present.
  - ISSUE to WAIT unconditionally.
  - WAIT to IDLE on Mem_Ready or on timeout.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesters: data wins, unless streak == MAX_DATA_STREAK, in which case the fetch wins.
- Streak counter:
  - Increments on each data grant made while InstMem_Read=1.
  - Clears on a fetch grant, or in any IDLE cycle with InstMem_Read=0.
  - Saturates at MAX_DATA_STREAK.
- Data-side precedence: DataMem_Read=1 means a read, whatever DataMem_Write is.
- Grant latching:
  - The grant registers {Mem_Address, Mem_WriteData, kind, owner}.
  - Mem_Address and Mem_WriteData hold after the strobe; only the strobes return to 0.
- Completion routing:
  - In WAIT, Mem_Ready asserts the owner's *_Ready combinationally in the same cycle.
  - The owner's *_In = Mem_ReadData for reads, 0 for writes.
- Watchdog:
  - Counts WAIT cycles; at TIMEOUT_CYCLES it pulses the owner's Ready.
  - On a timed-out read, *_In = TIMEOUT_DATA.
  - Sets Mem_Error; FSM returns to IDLE.
- Mem_Ready outside WAIT (late or spurious pulse) is ignored and has no side effect.
- Requester contract: the CPU drops or changes its request on the edge at which it samples Ready. IDLE therefore never re-grants a completed request.

## Timing
- Reset values: FSM=IDLE; all strobes, Ready, *_In, Mem_Address, Mem_WriteData, Mem_Error = 0; streak and watchdog = 0.
- Minimum latency, with a memory that answers one cycle after the strobe:
  - Request seen in IDLE at cycle 0.
  - Strobe in cycle 1.
  - Mem_Ready and *_Ready in cycle 2.
  - Next grant no earlier than cycle 3.
- Throughput: one access per 3 cycles at minimum latency.
- Both Ready outputs are never high in the same cycle.
- Exactly one strobe per grant.
- Reset asserted mid-access (ISSUE or WAIT):
  - Immediate return to IDLE; no Ready is emitted.
  - The outstanding Mem_Ready after reset release is ignored.
- Timeout and Mem_Ready in the same cycle: Mem_Ready wins, no error is flagged.

## Structure
- Package mips_mem_pkg holds:
  - enum arb_state_t {IDLE, ISSUE, WAIT}.
  - enum arb_owner_t {OWN_INST, OWN_DATA}.
  - A packed struct mem_cmd_t {addr, wdata, wr_en, rd}.
- One sub-module, mips_mem_watchdog, implements the timeout counter:
  - Inputs: clear and count enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES; 0 means never expire.

## Test plan
- Single fetch of 0x100 with the memory returning 0x2402000A one cycle after the strobe: one-cycle Mem_Read at cycle 1; InstMem_Ready and InstMem_In=0x2402000A at cycle 2; DataMem_Ready stays 0.
- Simultaneous fetch and data read, both held continuously: order D,D,D,D,I,D,…; streak resets after the forced fetch; no double Ready.
- Data write, DataMem_Write=4'b0011, addr 0x800, data 0x0000ACED: Mem_Write=4'b0011 for one cycle; Mem_WriteData=0x0000ACED; DataMem_Ready pulses; DataMem_In=0.
- Memory never answers, TIMEOUT_CYCLES=8, data read: DataMem_Ready 8 cycles after entering WAIT with DataMem_In=0xDEADDEAD; Mem_Error=1 and stays set; a later Mem_Ready is ignored.
- Reset pulsed low during WAIT, then a late Mem_Ready: all outputs 0 during reset; no Ready after release; the next request is served normally.
